// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the coefficient ROM read initiator.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/rom_reader_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Storage is cleared on reset so the head reads zero after reset.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rom_reader.sv
// Burst reader for the registered-output coefficient ROM.
// Streams LENGTH words from START_ADDR over valid/ready with a last flag.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 9,
    parameter int LENGTH     = 512,
    parameter int START_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [AWIDTH-1:0] rdaddr_o,
    input  logic [DWIDTH-1:0] rddata_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o
);

    localparam int CNTW = $clog2(LENGTH + 1);
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);
    localparam int OCW  = FCW + 1;
    localparam logic [AWIDTH-1:0] START    = AWIDTH'(START_ADDR);
    localparam logic [CNTW-1:0]   LAST_IDX = CNTW'(LENGTH - 1);

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              push_q, push_d;
    logic              push_last_q, push_last_d;
    logic              done_q, done_d;

    logic [DWIDTH:0]   head;
    logic              fifo_valid;
    logic [FCW-1:0]    fifo_count;
    logic [OCW-1:0]    occ;
    logic              room;
    logic              last_hs;

    sync_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_q),
        .wdata_i ({push_last_q, rddata_i}),
        .pop_i   (ready_i),
        .rdata_o (head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    // Buffered words plus reads still in the ROM pipeline must fit the FIFO.
    assign occ  = OCW'(fifo_count) + OCW'(rd_en_q) + OCW'(push_q);
    assign room = occ < OCW'(FIFO_DEPTH);
    assign last_hs = fifo_valid && ready_i && head[DWIDTH];

    assign valid_o  = fifo_valid;
    assign data_o   = head[DWIDTH-1:0];
    assign last_o   = fifo_valid && head[DWIDTH];
    assign busy_o   = (state_q != IDLE) || done_q;
    assign done_o   = done_q;
    assign rdaddr_o = addr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rd_en_d     = 1'b0;
        done_d      = 1'b0;
        push_d      = rd_en_q;
        push_last_d = rd_en_q && (cnt_q == LAST_IDX);
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    addr_d  = START;
                    rd_en_d = 1'b1;
                end
            end
            RUN: begin
                if (rd_en_q && (cnt_q == LAST_IDX)) begin
                    state_d = DRAIN;
                end else if (room) begin
                    rd_en_d = 1'b1;
                    cnt_d   = cnt_q + CNTW'(1);
                    addr_d  = addr_q + AWIDTH'(1);
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= START;
            rd_en_q     <= 1'b0;
            push_q      <= 1'b0;
            push_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            push_q      <= push_d;
            push_last_q <= push_last_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader against a 16-word model ROM (mem[a]=0xB0+a).
module tb_rom_reader;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_ni, start_i, ready_i;
    logic       busy_o, done_o, valid_o, last_o;
    logic [3:0] rdaddr_o;
    logic [7:0] rddata_i, data_o;

    logic       start2, ready2;
    logic       busy2, done2, valid2, last2;
    logic [3:0] rdaddr2;
    logic [7:0] rddata2, data2;

    rom_reader #(
        .DWIDTH(8), .AWIDTH(4), .LENGTH(16), .START_ADDR(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .rdaddr_o(rdaddr_o),
        .rddata_i(rddata_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .last_o(last_o)
    );

    rom_reader #(
        .DWIDTH(8), .AWIDTH(4), .LENGTH(4), .START_ADDR(14)
    ) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start2),
        .busy_o(busy2), .done_o(done2), .rdaddr_o(rdaddr2),
        .rddata_i(rddata2), .data_o(data2), .valid_o(valid2),
        .ready_i(ready2), .last_o(last2)
    );

    always @(posedge clk) begin
        rddata_i <= 8'hB0 + {4'h0, rdaddr_o};
        rddata2  <= 8'hB0 + {4'h0, rdaddr2};
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [8:0] exp_q[$];
    logic [8:0] exp2_q[$];

    int  c0, first_v, done_cyc, n_busy, n_done, n_words, n_last;
    bit  seen_v;
    int  n_done2, n_words2, n_last2;
    logic pv = 0, pr = 0, pl = 0, prst = 0;
    logic [7:0] pd = '0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_ni) begin
            if (pv && !pr && prst) begin
                check("hold_valid", 32'(valid_o), 32'd1);
                check("hold_data", 32'(data_o), 32'(pd));
                check("hold_last", 32'(last_o), 32'(pl));
            end
            if (valid_o && !seen_v) begin
                first_v = cyc;
                seen_v  = 1'b1;
            end
            if (busy_o) n_busy++;
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            if (valid_o && ready_i) begin
                n_words++;
                if (last_o) n_last++;
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(data_o), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(data_o), 32'(e[7:0]));
                    check("last", 32'(last_o), 32'(e[8]));
                end
            end
        end
        pv = valid_o; pr = ready_i; pd = data_o;
        pl = last_o;  prst = rst_ni;
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_ni) begin
            if (done2) n_done2++;
            if (valid2 && ready2) begin
                n_words2++;
                if (last2) n_last2++;
                if (exp2_q.size() == 0) begin
                    check("extra_word2", 32'(data2), 32'hFFFF);
                end else begin
                    e = exp2_q.pop_front();
                    check("data2", 32'(data2), 32'(e[7:0]));
                    check("last2", 32'(last2), 32'(e[8]));
                end
            end
        end
    end

    task automatic push_burst();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 8'hB0 + 8'(i);
            exp_q.push_back({(i == 15), v});
        end
    endtask

    // mode: 0 ready high, 1 stall cycles 3..12, 2 random ready,
    //       3 extra starts in RUN + restart on done, 4 reset after 5 words
    task automatic burst(input int mode, input bit pre);
        bit ended = 1'b0;
        if (!pre) begin
            @(posedge clk); #1;
            start_i = 1'b1;
        end
        ready_i  = 1'b1;
        c0       = cyc;
        seen_v   = 1'b0;
        first_v  = -1;
        done_cyc = -1;
        n_busy   = 0;
        n_done   = 0;
        n_words  = 0;
        n_last   = 0;
        push_burst();
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            start_i = (mode == 3) && (k == 2 || k == 4 || k == 6);
            case (mode)
                1:       ready_i = !(k >= 3 && k <= 12);
                2:       ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b1;
            endcase
            if (mode == 1 && k == 12) begin
                check("stall_addr", 32'(rdaddr_o), 32'd3);
                check("stall_valid", 32'(valid_o), 32'd1);
                check("stall_data", 32'(data_o), 32'hB0);
            end
            if (mode == 4 && n_words >= 5) begin
                ready_i = 1'b0;
                rst_ni  = 1'b0;
                @(posedge clk); #1;
                rst_ni  = 1'b1;
                ready_i = 1'b1;
                check("rst_valid", 32'(valid_o), 32'd0);
                check("rst_busy", 32'(busy_o), 32'd0);
                check("rst_addr", 32'(rdaddr_o), 32'd0);
                check("rst_data", 32'(data_o), 32'd0);
                check("rst_last", 32'(last_o), 32'd0);
                exp_q.delete();
                ended = 1'b1;
                break;
            end
            if (mode == 3 && k == 19) begin
                start_i = 1'b1;
                @(negedge clk); #1;
                check("done_with_start", 32'(done_o), 32'd1);
                ended = 1'b1;
                break;
            end
            if (mode != 3 && n_done > 0) begin
                ended = 1'b1;
                break;
            end
        end
        if (!ended) check("burst_timeout", 32'd0, 32'd1);
        if (mode != 4) begin
            check("words", 32'(n_words), 32'd16);
            check("n_last", 32'(n_last), 32'd1);
            check("n_done", 32'(n_done), 32'd1);
            check("queue_empty", 32'(exp_q.size()), 32'd0);
        end
        if (mode == 0 || mode == 3) begin
            check("first_valid_cyc", 32'(first_v), 32'(c0 + 3));
            check("done_cyc", 32'(done_cyc), 32'(c0 + 19));
            if (!pre) check("busy_cycles", 32'(n_busy), 32'd19);
        end
        if (mode == 0 && !pre) check("busy_after", 32'(busy_o), 32'd0);
    endtask

    task automatic burst_wrap();
        logic [7:0] v;
        bit ended = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 8'hB0 + 8'((14 + i) % 16);
            exp2_q.push_back({(i == 3), v});
        end
        n_done2  = 0;
        n_words2 = 0;
        n_last2  = 0;
        @(posedge clk); #1;
        start2 = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (n_done2 > 0) begin
                ended = 1'b1;
                break;
            end
        end
        if (!ended) check("wrap_timeout", 32'd0, 32'd1);
        check("wrap_words", 32'(n_words2), 32'd4);
        check("wrap_last", 32'(n_last2), 32'd1);
        check("wrap_queue", 32'(exp2_q.size()), 32'd0);
    endtask

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b1;
        start2  = 1'b0;
        ready2  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_last", 32'(last_o), 32'd0);
        check("reset_addr", 32'(rdaddr_o), 32'd0);
        check("reset_data", 32'(data_o), 32'd0);
        check("reset_addr2", 32'(rdaddr2), 32'd14);
        check("reset_valid2", 32'(valid2), 32'd0);

        burst(0, 1'b0);
        burst_wrap();
        burst(1, 1'b0);
        burst(2, 1'b0);
        burst(3, 1'b0);
        burst(0, 1'b1);
        burst(4, 1'b0);
        burst(0, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_reader.md
Name: rom_reader

Overview:
- Read initiator for the single-port synchronous coefficient ROM, which has a registered output and 1-cycle read latency.
- On a start pulse, reads LENGTH consecutive words starting at START_ADDR and streams them out over a valid/ready interface with a last flag.
- Sits between the coefficient ROM and the FIR tap/MAC datapath.
- Absorbs the ROM pipeline latency and downstream backpressure with a small internal FIFO. No word is lost or duplicated.

Parameters:
- DWIDTH, 16, ROM word width and data_o width.
- AWIDTH, 9, ROM address width.
- LENGTH, 512, words per burst; legal range 1..2**AWIDTH.
- START_ADDR, 0, first ROM address of a burst.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- start_i  in  1  burst request; sampled only in IDLE.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse after the last word's handshake.
- rdaddr_o  out  AWIDTH  ROM read address (registered).
- rddata_i  in  DWIDTH  ROM read data, valid 1 cycle after rdaddr_o.
- data_o  out  DWIDTH  streamed word.
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream ready.
- last_o  out  1  qualifies the final word of a burst; meaningful only with valid_o.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - FSM goes to IDLE; counters and FIFO are cleared; in-flight ROM reads are discarded.
  - Outputs: busy_o=0, done_o=0, valid_o=0, last_o=0, rdaddr_o=START_ADDR, data_o=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when start_i=1. The issue counter loads 0 and the issue address loads START_ADDR.
  - RUN -> DRAIN in the cycle the LENGTH-th read is issued.
  - DRAIN -> IDLE at the handshake of the word with last_o=1; done_o=1 in the following cycle.
  - start_i in RUN or DRAIN is ignored, not queued.
- Issue rule:
  - A read is "issued" in a cycle where rdaddr_o presents a new address and the internal rd_en register is 1.
  - Issue is allowed only when fifo_count + inflight < 4. inflight counts registered read-enable pipeline stages (0..2).
  - When not issuing, rdaddr_o holds its value; the resulting ROM reads are harmless and ignored.
- Address arithmetic:
  - The i-th issued address is (START_ADDR + i) mod 2**AWIDTH; wrap-around is silent.
  - The issue counter is clog2(LENGTH+1) bits wide.
- Data path:
  - rddata_i is captured into a 4-entry FIFO in the cycle after the issue cycle, tagged with a last bit (i == LENGTH-1).
  - data_o, valid_o and last_o are driven from the FIFO head.
  - Pop on valid_o && ready_i.
  - The FIFO never overflows by construction; simultaneous push and pop are allowed.
- Latency and throughput:
  - start_i high in cycle 0 -> first issue in cycle 1 -> ROM data in cycle 2 -> valid_o in cycle 3.
  - With ready_i held high, 1 word/cycle sustained.
- valid/ready:
  - Once valid_o=1, data_o and last_o stay stable until the handshake.
  - valid_o does not depend combinationally on ready_i.
- LENGTH=1: a single word with last_o=1; FSM goes directly RUN->DRAIN.
- A new start_i is accepted in IDLE in the same cycle done_o=1.

Decomposition:
- rom_reader_pkg holds:
  - state_t enum {IDLE, RUN, DRAIN};
  - localparam FIFO_DEPTH=4;
  - localparam RD_LATENCY=1.
- One sub-module: sync_fifo (DWIDTH+1 wide, depth FIFO_DEPTH, show-ahead, count output). The issue FSM and counters stay in the top module.

Test Plan:
All scenarios use a 16-word test ROM with mem[a]=0xB0+a, AWIDTH=4, DWIDTH=8.
1. LENGTH=16, START_ADDR=0, ready_i=1, start_i pulse in cycle 0 -> data_o 0xB0..0xBF in cycles 3..18, last_o only on 0xBF, done_o in cycle 19, busy_o high cycles 1..19.
2. LENGTH=4, START_ADDR=14 -> words 0xBE, 0xBF, 0xB0, 0xB1 (address wrap); last_o on 0xB1.
3. LENGTH=16, ready_i low for cycles 3..12 then high:
   - rdaddr_o stops advancing once 4 words are buffered plus in flight;
   - the output sequence is still exactly 0xB0..0xBF with no gaps or duplicates;
   - valid_o and data_o stay stable while stalled.
4. Random ready_i (50%), LENGTH=16 -> scoreboard matches 0xB0..0xBF in order; exactly one last_o and one done_o.
5. Repeated start_i pulses during RUN -> ignored; exactly 16 words. A start_i in the done_o cycle -> a second burst begins with valid_o 3 cycles later.
6. rst_ni low for 1 cycle after the 5th handshake -> next cycle valid_o=0, busy_o=0, rdaddr_o=START_ADDR. A new start then yields 0xB0 first, with no stale data.
